// File: rtl/io_check.sv
`default_nettype none
// ============================================================================
// Module   : io_check
// Brief    : Loopback checker for the header IO toggle test (stuck / mismatch /
//            toggle-interval detection with a single pass/fail verdict).
// Revision : 1.0 - initial release
// ============================================================================
module io_check #(
    parameter int unsigned WIDTH        = 34,
    parameter int unsigned HALF_PERIOD  = 25_000_000,
    parameter int unsigned TOL          = 1_000,
    parameter int unsigned SKEW         = 16,
    parameter int unsigned PASS_TOGGLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] io_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timing_err,
    output logic [WIDTH-1:0] stuck_mask,
    output logic [WIDTH-1:0] mismatch_mask,
    output logic [7:0]       toggle_cnt
);

    localparam logic [31:0] C_WAIT_LIMIT = 32'(2 * HALF_PERIOD + TOL);
    localparam logic [31:0] C_MEAS_LIMIT = 32'(HALF_PERIOD + TOL + 1);
    localparam logic [31:0] C_INT_MIN    = 32'(HALF_PERIOD - TOL);
    localparam logic [31:0] C_INT_MAX    = 32'(HALF_PERIOD + TOL);
    localparam logic [31:0] C_SKEW       = 32'(SKEW);
    localparam logic [7:0]  C_PASS       = 8'(PASS_TOGGLES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EDGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    logic [WIDTH-1:0] sync_meta_q;
    logic [WIDTH-1:0] sio_q;
    logic [WIDTH-1:0] sio_prev_q;

    state_t           state_q,    state_d;
    logic [31:0]      cnt_q,      cnt_d;
    logic [7:0]       toggle_q,   toggle_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic             terr_q,     terr_d;
    logic [WIDTH-1:0] stuck_q,    stuck_d;
    logic [WIDTH-1:0] mismatch_q, mismatch_d;

    logic             w_ref_edge;
    logic [WIDTH-1:0] w_changed;
    logic [WIDTH-1:0] w_skew_diff;
    logic [31:0]      w_cnt_inc;
    logic [7:0]       w_toggle_inc;
    logic             w_begin;
    logic             w_finish;

    // Data path only: the synchronizer and edge history carry no reset so a
    // reset never fabricates an edge on the reference bit.
    always_ff @(posedge clk) begin
        sync_meta_q <= io_in;
        sio_q       <= sync_meta_q;
        sio_prev_q  <= sio_q;
    end

    assign w_ref_edge   = sio_q[0] ^ sio_prev_q[0];
    assign w_changed    = sio_q ^ sio_prev_q;
    assign w_skew_diff  = sio_q ^ {WIDTH{sio_q[0]}};
    assign w_cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign w_toggle_inc = (toggle_q == 8'hFF) ? toggle_q : toggle_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        toggle_d   = toggle_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        terr_d     = terr_q;
        stuck_d    = stuck_q;
        mismatch_d = mismatch_q;
        w_begin    = 1'b0;
        w_finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                w_begin = start;
            end
            S_WAIT_EDGE: begin
                stuck_d = stuck_q & ~w_changed;
                if (w_ref_edge) begin
                    cnt_d   = 32'd0;
                    state_d = S_MEASURE;
                end else if (cnt_q >= C_WAIT_LIMIT) begin
                    terr_d   = 1'b1;
                    w_finish = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            S_MEASURE: begin
                stuck_d = stuck_q & ~w_changed;
                cnt_d   = w_cnt_inc;
                if (cnt_q == C_SKEW) begin
                    mismatch_d = mismatch_q | w_skew_diff;
                end
                if (w_ref_edge) begin
                    if ((cnt_q < C_INT_MIN) || (cnt_q > C_INT_MAX)) begin
                        terr_d = 1'b1;
                    end
                    toggle_d = w_toggle_inc;
                    cnt_d    = 32'd0;
                end else if (cnt_q >= C_MEAS_LIMIT) begin
                    terr_d   = 1'b1;
                    w_finish = 1'b1;
                end else if ((cnt_q == C_SKEW) && (toggle_q >= C_PASS)) begin
                    // Final interval: its skew compare above is folded in first.
                    w_finish = 1'b1;
                end
            end
            S_DONE: begin
                w_begin = start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_finish) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = ~terr_d & ~(|stuck_d) & ~(|mismatch_d);
        end

        if (w_begin) begin
            state_d    = S_WAIT_EDGE;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            terr_d     = 1'b0;
            mismatch_d = '0;
            stuck_d    = '1;
            toggle_d   = 8'd0;
            cnt_d      = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            toggle_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            terr_q     <= 1'b0;
            stuck_q    <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            toggle_q   <= toggle_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            terr_q     <= terr_d;
            stuck_q    <= stuck_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timing_err    = terr_q;
    assign stuck_mask    = stuck_q;
    assign mismatch_mask = mismatch_q;
    assign toggle_cnt    = toggle_q;

endmodule
`default_nettype wire
